// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer: multicycle fetch / next-PC controller for the PC register |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pcnext,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_err,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        trap,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        fault,
  output logic [2:0]  state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] HALT  = 3'd3;
  localparam logic [2:0] DEAD  = 3'd4;

  localparam int unsigned   TW       = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_ERR = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  logic [2:0]    state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   epc_q, epc_d;
  logic [1:0]    cause_q, cause_d;
  logic          fault_q, fault_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [31:0] pc_seq;
  logic        fetch_ok;
  logic        fetch_err;
  logic        fetch_tmo;

  always_comb begin
    pc_seq    = pc + 32'd4;
    fetch_ok  = imem_ack && !imem_err;
    fetch_err = imem_ack && imem_err;
    // An ack in the final counted cycle beats the timeout.
    fetch_tmo = !imem_ack && (tmo_q == TMO_LAST);

    state_d = state_q;
    instr_d = instr_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    fault_d = fault_q;
    tmo_d   = '0;
    pcnext  = pc;

    case (state_q)
      IDLE: begin
        pcnext  = RESET_PC;
        state_d = FETCH;
      end
      FETCH: begin
        if (fetch_ok) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end else if (fetch_err || fetch_tmo) begin
          // A second fault while the first is still recorded is unrecoverable.
          if (fault_q) begin
            state_d = DEAD;
          end else begin
            epc_d   = pc;
            cause_d = fetch_err ? CAUSE_IMEM_ERR : CAUSE_TIMEOUT;
            fault_d = 1'b1;
            pcnext  = TRAP_VEC;
            state_d = FETCH;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      EXEC: begin
        if (trap) begin
          epc_d   = pc;
          pcnext  = TRAP_VEC;
          state_d = FETCH;
        end else if (redirect) begin
          if (redirect_target[1:0] != 2'b00) begin
            epc_d   = pc;
            cause_d = CAUSE_MISALIGN;
            pcnext  = TRAP_VEC;
          end else begin
            pcnext  = redirect_target;
          end
          state_d = FETCH;
        end else if (stall) begin
          state_d = EXEC;
        end else if (halt) begin
          pcnext  = pc_seq;
          state_d = HALT;
        end else begin
          pcnext  = pc_seq;
          state_d = FETCH;
        end
      end
      HALT: begin
        if (resume) begin
          state_d = FETCH;
        end
      end
      DEAD: begin
        state_d = DEAD;
      end
      default: begin
        pcnext  = RESET_PC;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      fault_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state_q == EXEC);
  assign instr       = instr_q;
  assign epc         = epc_q;
  assign cause       = cause_q;
  assign fault       = fault_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_sequencer: self-checking bench for fetch_sequencer                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC    = 32'h0000_0100;
  localparam int          MEM_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] pcnext;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_err = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        trap = 1'b0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        fault;
  logic [2:0]  state;

  logic        force_en = 1'b0;
  logic [31:0] force_val = 32'h0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .pcnext(pcnext),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_err(imem_err), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .trap(trap), .halt(halt),
    .resume(resume), .epc(epc), .cause(cause), .fault(fault), .state(state)
  );

  // The PC register this block feeds; force_en lets a test plant an arbitrary PC.
  always_ff @(posedge clk) begin
    pc <= force_en ? force_val : pcnext;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 fetching, 2 executing, 3 halted, 4 dead.
  int          m_mode, p_mode;
  int          m_waited, p_waited;
  logic [31:0] m_instr, p_instr, m_epc, p_epc, p_pcnext;
  logic [1:0]  m_cause, p_cause;
  logic        m_fault, p_fault;

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_instr = '0; m_epc = '0; m_cause = '0; m_fault = 1'b0;
  endtask

  task automatic plan();
    p_mode = m_mode; p_waited = 0; p_pcnext = pc;
    p_instr = m_instr; p_epc = m_epc; p_cause = m_cause; p_fault = m_fault;
    if (reset) begin
      p_mode = 0; p_pcnext = RESET_PC; p_instr = '0; p_epc = '0; p_cause = '0; p_fault = 1'b0;
    end else begin
      case (m_mode)
        0: begin p_pcnext = RESET_PC; p_mode = 1; end
        1: begin
          if (imem_ack && !imem_err) begin
            p_instr = mem_word(pc); p_mode = 2;
          end else if (imem_ack || (m_waited + 1 >= MEM_TIMEOUT)) begin
            if (m_fault) p_mode = 4;
            else begin
              p_epc = pc; p_cause = imem_ack ? 2'd2 : 2'd3; p_fault = 1'b1; p_pcnext = TRAP_VEC;
            end
          end else begin
            p_waited = m_waited + 1;
          end
        end
        2: begin
          if (trap) begin
            p_epc = pc; p_pcnext = TRAP_VEC; p_mode = 1;
          end else if (redirect && (redirect_target % 4 != 0)) begin
            p_epc = pc; p_cause = 2'd1; p_pcnext = TRAP_VEC; p_mode = 1;
          end else if (redirect) begin
            p_pcnext = redirect_target; p_mode = 1;
          end else if (stall) begin
            p_mode = 2;
          end else begin
            p_pcnext = pc + 32'd4; p_mode = halt ? 3 : 1;
          end
        end
        3: p_mode = resume ? 1 : 3;
        default: p_mode = 4;
      endcase
    end
  endtask

  task automatic sample_and_check();
    @(negedge clk);
    plan();
    chk("m_state", 32'(state), 32'(m_mode));
    chk("m_pcnext", pcnext, p_pcnext);
    chk("m_imem_req", 32'(imem_req), 32'(m_mode == 1));
    chk("m_instr_valid", 32'(instr_valid), 32'(m_mode == 2));
    chk("m_imem_addr", imem_addr, pc);
    chk("m_instr", instr, m_instr);
    chk("m_epc", epc, m_epc);
    chk("m_cause", 32'(cause), 32'(m_cause));
    chk("m_fault", 32'(fault), 32'(m_fault));
  endtask

  task automatic advance();
    m_mode = p_mode; m_waited = p_waited; m_instr = p_instr;
    m_epc = p_epc; m_cause = p_cause; m_fault = p_fault;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample_and_check();
    advance();
  endtask

  task automatic clear_inputs();
    imem_ack = 1'b0; imem_err = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_target = 32'h0; trap = 1'b0; halt = 1'b0; resume = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_pcnext", pcnext, RESET_PC);
    chk("rst_state", 32'(state), 32'd0);
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic goto_fetch(input logic [31:0] a);
    int n;
    n = 0;
    imem_ack = 1'b1;
    while (!(state == 3'd1 && pc == a) && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL goto_fetch actual_pc=0x%08h required_pc=0x%08h", pc, a);
    end
  endtask

  typedef struct {
    logic        ack;
    logic        redir;
    logic [31:0] tgt;
    logic [2:0]  st;
    logic [31:0] pc;
    logic [31:0] pn;
    logic        req;
    logic        val;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic        fault;
  } vec_t;

  vec_t tbl [0:12];

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h00, 3'd0, 32'h000, 32'h000, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h00, 3'd1, 32'h000, 32'h000, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h00, 3'd2, 32'h000, 32'h004, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h00, 3'd1, 32'h004, 32'h004, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h00, 3'd2, 32'h004, 32'h008, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h00, 3'd1, 32'h008, 32'h008, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'h40, 3'd2, 32'h008, 32'h040, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h00, 3'd1, 32'h040, 32'h040, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 32'h08, 3'd2, 32'h040, 32'h008, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h00, 3'd1, 32'h008, 32'h008, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'h42, 3'd2, 32'h008, 32'h100, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h00, 3'd1, 32'h100, 32'h100, 1'b1, 1'b0, 2'd1, 32'h8, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h00, 3'd2, 32'h100, 32'h104, 1'b0, 1'b1, 2'd1, 32'h8, 1'b0};

    clear_inputs();
    model_reset();
    #2;
    apply_reset(2);

    // Straight-line fetch with ack tied high, then aligned and misaligned redirects.
    for (int i = 0; i < 13; i++) begin
      imem_ack = tbl[i].ack;
      redirect = tbl[i].redir;
      redirect_target = tbl[i].tgt;
      sample_and_check();
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("vec%0d_pcnext", i), pcnext, tbl[i].pn);
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tbl[i].val));
      chk($sformatf("vec%0d_cause", i), 32'(cause), 32'(tbl[i].cause));
      chk($sformatf("vec%0d_epc", i), epc, tbl[i].epc);
      chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(tbl[i].fault));
      if (tbl[i].st == 3'd2) chk($sformatf("vec%0d_instr", i), instr, mem_word(tbl[i].pc));
      advance();
    end
    clear_inputs();

    // Timeout at 0xC, then an imem error while already faulted.
    apply_reset(1);
    goto_fetch(32'hC);
    imem_ack = 1'b0;
    repeat (MEM_TIMEOUT - 1) cycle();
    chk("tmo_pre_state", 32'(state), 32'd1);
    chk("tmo_pre_fault", 32'(fault), 32'd0);
    cycle();
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_cause", 32'(cause), 32'd3);
    chk("tmo_epc", epc, 32'hC);
    chk("tmo_pc", pc, TRAP_VEC);
    chk("tmo_state", 32'(state), 32'd1);
    imem_ack = 1'b1; imem_err = 1'b1;
    cycle();
    imem_err = 1'b0;
    chk("dead_state", 32'(state), 32'd4);
    repeat (3) cycle();
    chk("dead_req", 32'(imem_req), 32'd0);
    chk("dead_valid", 32'(instr_valid), 32'd0);
    chk("dead_pc", pc, TRAP_VEC);
    clear_inputs();

    // Ack in the very cycle the timeout would fire.
    apply_reset(1);
    goto_fetch(32'h0);
    imem_ack = 1'b0;
    repeat (MEM_TIMEOUT - 1) cycle();
    imem_ack = 1'b1;
    cycle();
    chk("ackwin_state", 32'(state), 32'd2);
    chk("ackwin_fault", 32'(fault), 32'd0);
    chk("ackwin_cause", 32'(cause), 32'd0);
    clear_inputs();

    // Stall for three EXEC cycles, then stall and trap together.
    apply_reset(1);
    goto_fetch(32'h4);
    cycle();
    imem_ack = 1'b1;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_pc", pc, 32'h4);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_instr", instr, mem_word(32'h4));
      chk("stall_state", 32'(state), 32'd2);
    end
    trap = 1'b1;
    cycle();
    chk("trap_pc", pc, TRAP_VEC);
    chk("trap_epc", epc, 32'h4);
    chk("trap_cause", 32'(cause), 32'd0);
    chk("trap_fault", 32'(fault), 32'd0);
    clear_inputs();

    // Halt at 0x10 and resume.
    apply_reset(1);
    goto_fetch(32'h10);
    cycle();
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_pc", pc, 32'h14);
    imem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_pc_hold", pc, 32'h14);
    end
    resume = 1'b1;
    cycle();
    resume = 1'b0;
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_addr", imem_addr, 32'h14);
    clear_inputs();

    // PC wrap on a sequential EXEC at the top of the address space.
    apply_reset(1);
    goto_fetch(32'h4);
    force_en = 1'b1;
    force_val = 32'hFFFF_FFFC;
    cycle();
    force_en = 1'b0;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pcnext", pcnext, 32'h0);
    cycle();
    chk("wrap_next_pc", pc, 32'h0);
    chk("wrap_next_state", 32'(state), 32'd1);
    clear_inputs();

    // Reset asserted in the middle of a fetch wait.
    goto_fetch(32'h8);
    imem_ack = 1'b0;
    cycle();
    imem_ack = 1'b1;
    apply_reset(2);
    cycle();
    chk("rst_first_state", 32'(state), 32'd1);
    chk("rst_first_addr", imem_addr, RESET_PC);
    clear_inputs();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        clear_inputs();
        apply_reset(int'($urandom_range(1, 2)));
      end
      imem_ack        = ($urandom_range(0, 9) < 7);
      imem_err        = ($urandom_range(0, 29) == 0);
      stall           = ($urandom_range(0, 4) == 0);
      redirect        = ($urandom_range(0, 6) == 0);
      redirect_target = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      trap            = ($urandom_range(0, 19) == 0);
      halt            = ($urandom_range(0, 19) == 0);
      resume          = ($urandom_range(0, 2) == 0);
      cycle();
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multicycle fetch/next-PC controller that sequences the 32-bit PC register. It drives the register's `pcnext` input every cycle, issues instruction-memory requests at the current `pc`, and presents each fetched instruction to the core for one execute cycle. It also resolves stall, branch/jump redirect, trap, halt and memory-fault events into the next PC value. The block sits between the PC register, instruction memory and the core datapath/decoder.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on the first edge after reset release.
- `TRAP_VEC`, 32'h0000_0100, PC loaded on any trap or fault.
- `MEM_TIMEOUT`, 16, cycles in FETCH without `imem_ack` before a timeout fault; legal range ≥2.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pc`  in  32  current PC from the PC register.
- `pcnext`  out  32  combinational next PC to the PC register.
- `imem_req`  out  1  fetch request, combinational from state.
- `imem_addr`  out  32  equals `pc`.
- `imem_ack`  in  1  fetch complete this cycle.
- `imem_err`  in  1  fetch error; qualified by `imem_ack`.
- `imem_rdata`  in  32  instruction word; valid with `imem_ack`.
- `instr`  out  32  registered instruction.
- `instr_valid`  out  1  high during EXEC.
- `stall`  in  1  core hold, sampled in EXEC.
- `redirect`  in  1  taken branch/jump, sampled in EXEC.
- `redirect_target`  in  32  redirect destination.
- `trap`  in  1  core exception, sampled in EXEC.
- `halt`  in  1  stop after the current instruction, sampled in EXEC.
- `resume`  in  1  leave HALT.
- `epc`  out  32  PC of the trapping or faulting instruction.
- `cause`  out  2  0 none, 1 misaligned target, 2 imem_err, 3 timeout. `trap` leaves `cause` unchanged.
- `fault`  out  1  sticky; set on cause 2 or 3; cleared only by reset.
- `state`  out  3  FSM state encoding, for debug.

## Operation
- States: IDLE=0, FETCH=1, EXEC=2, HALT=3, DEAD=4.
- IDLE: `imem_req`=0, `pcnext`=RESET_PC; always advances to FETCH.
- FETCH: `imem_req`=1, `pcnext`=`pc`.
  - `imem_ack` && !`imem_err`: latch `instr`←`imem_rdata`; go to EXEC.
  - `imem_ack` && `imem_err`: fault with cause 2.
  - Timeout counter reaches MEM_TIMEOUT-1 with no ack: fault with cause 3.
- Fault handling:
  - If `fault` is already set, go to DEAD.
  - Otherwise set `epc`←`pc`, `cause`, `fault`=1; `pcnext`=TRAP_VEC; go to FETCH.
- EXEC: `instr_valid`=1, `imem_req`=0. Priority is trap > redirect > stall > halt > sequential.
  - `trap`: `epc`←`pc`, `pcnext`=TRAP_VEC, go to FETCH.
  - `redirect` with `redirect_target[1:0]`≠0: `epc`←`pc`, `cause`←1, `pcnext`=TRAP_VEC, go to FETCH.
  - `redirect` (aligned): `pcnext`=`redirect_target`, go to FETCH.
  - `stall`: `pcnext`=`pc`, stay in EXEC; `instr` is held.
  - `halt`: `pcnext`=`pc`+4, go to HALT.
  - Otherwise: `pcnext`=`pc`+4, go to FETCH.
- HALT: `pcnext`=`pc`, `imem_req`=0; `resume` → FETCH.
- DEAD: `pcnext`=`pc`, `imem_req`=0, `instr_valid`=0. Only reset exits DEAD.
- `pc`+4 is computed mod 2^32: 0xFFFF_FFFC → 0x0000_0000.
- `imem_ack` outside FETCH is ignored.
- `redirect_target` is ignored unless `redirect`=1.

## Timing
- Reset values: state=IDLE, `instr`=0, `epc`=0, `cause`=0, `fault`=0, timeout counter=0.
- While reset is asserted: `imem_req`=0, `instr_valid`=0, `pcnext`=RESET_PC.
- Reset is asynchronous. Asserting it mid-FETCH drops `imem_req` in the same cycle and discards any pending ack.
- Minimum 2 cycles per instruction: ack in the first FETCH cycle, then one EXEC cycle.
- Each extra wait cycle in FETCH adds one cycle.
- The timeout counter clears on every entry to FETCH. A timeout fires in the MEM_TIMEOUT-th consecutive FETCH cycle without ack.
- An ack arriving in the same cycle the timeout fires wins; no fault is raised.
- `instr` updates on the edge leaving FETCH and is stable for the whole EXEC period, including stalls.
- `epc`, `cause` and `fault` update on the same edge as the PC load.

## Test plan
- Reset release with `imem_ack` tied 1: `pc` = 0x0, 0x4, 0x8 for 2 cycles each; `instr_valid` high every other cycle; `instr` matches memory words.
- `redirect`=1, target 0x40, in EXEC at `pc`=0x8: next FETCH has `imem_addr`=0x40. Repeat with target 0x42: `pc`=0x100, `cause`=1, `epc`=0x8, `fault`=0.
- Ack withheld 16 cycles at `pc`=0xC: `fault`=1, `cause`=3, `epc`=0xC, `pc`=0x100. Then `imem_ack`+`imem_err` at 0x100: state=DEAD, `imem_req`=0 thereafter.
- `stall` high 3 EXEC cycles at `pc`=0x4: `pc` held, `imem_req`=0, `instr` unchanged. Then `stall`+`trap` together: `pc`=0x100, `epc`=0x4.
- `halt` in EXEC at `pc`=0x10: state=HALT, `pc`=0x14, no requests. `resume` pulse: FETCH at 0x14.
- Force `pc`=0xFFFF_FFFC with a sequential EXEC: `pcnext`=0x0. Separately, assert `reset` mid-FETCH: `imem_req`=0 in the same cycle; after release, first fetch is at RESET_PC.
